sdram_rw_tester: RTL and testbench

//  User-side initiator for the sdram_module3 request interface (WrEN_Sig/RdEN_Sig/Done_Sig/Busy_Sig).

---
 rtl/sdram_rw_tester_if.sv | 27 ++
 rtl/sdram_rw_tester.sv | 201 ++++++++++++++++++++
 tb/tb_sdram_rw_tester.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_rw_tester_if.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_rw_tester_if
//  Brief    : Request/response bundle between the pattern tester and the
//             SDRAM controller user port.
//  Revision : 1.0
// ============================================================================
interface sdram_rw_tester_if;
    logic        WrEN_Sig;
    logic        RdEN_Sig;
    logic [21:0] BRC_Addr;
    logic [15:0] WrData;
    logic        Done_Sig;
    logic        Busy_Sig;
    logic [15:0] RdData;

    modport master (
        output WrEN_Sig, RdEN_Sig, BRC_Addr, WrData,
        input  Done_Sig, Busy_Sig, RdData
    );

    modport slave (
        input  WrEN_Sig, RdEN_Sig, BRC_Addr, WrData,
        output Done_Sig, Busy_Sig, RdData
    );
endinterface
`default_nettype wire

// File: rtl/sdram_rw_tester.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_rw_tester
//  Brief    : Writes addr^SEED over an address window, reads it back, and
//             reports pass/fail, error count and first failing address.
//  Revision : 1.0
// ============================================================================
module sdram_rw_tester #(
    parameter logic [21:0] ADDR_FIRST = 22'd0,
    parameter logic [21:0] ADDR_LAST  = 22'd255,
    parameter logic [15:0] SEED       = 16'hA5C3,
    parameter logic [15:0] TIMEOUT    = 16'd4095,
    parameter int          ERR_W      = 8
) (
    input  wire logic             CLK,
    input  wire logic             RSTn,
    input  wire logic             Start_Sig,
    sdram_rw_tester_if.master     bus,
    output logic                  Run_Sig,
    output logic                  Pass_Sig,
    output logic                  Fail_Sig,
    output logic                  Timeout_Sig,
    output logic [ERR_W-1:0]      Err_Count,
    output logic [21:0]           First_Err_Addr
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_REQ = 3'd1,
        S_WR_GAP = 3'd2,
        S_RD_REQ = 3'd3,
        S_RD_GAP = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    localparam logic [ERR_W-1:0] c_ERR_MAX   = '1;
    localparam logic [ERR_W-1:0] c_ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]      c_WDOG_LAST = TIMEOUT - 16'd1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [21:0]       r_addr;
    logic [15:0]       r_wdog;
    logic              r_wr_en;
    logic              r_rd_en;
    logic              r_run;
    logic              r_pass;
    logic              r_fail;
    logic              r_timeout;
    logic [ERR_W-1:0]  r_err_cnt;
    logic [21:0]       r_first_err;

    logic              w_en;
    logic              w_in_req;
    logic              w_done;
    logic              w_timeout;
    logic              w_last;
    logic              w_mismatch;
    logic              w_req_issue;
    logic [15:0]       w_pattern;

    assign w_en       = r_wr_en | r_rd_en;
    assign w_in_req   = (r_state == S_WR_REQ) || (r_state == S_RD_REQ);
    assign w_done     = w_in_req && w_en && bus.Done_Sig;
    assign w_timeout  = w_in_req && !w_done && (r_wdog == c_WDOG_LAST);
    assign w_last     = (r_addr == ADDR_LAST);
    assign w_pattern  = r_addr[15:0] ^ SEED;
    assign w_mismatch = (r_state == S_RD_REQ) && w_done && (bus.RdData != w_pattern);

    // Address/data are only meaningful while a request is open; idle bus reads as zero.
    assign bus.WrEN_Sig = r_wr_en;
    assign bus.RdEN_Sig = r_rd_en;
    assign bus.BRC_Addr = w_en    ? r_addr    : 22'd0;
    assign bus.WrData   = r_wr_en ? w_pattern : 16'd0;

    assign Run_Sig        = r_run;
    assign Pass_Sig       = r_pass;
    assign Fail_Sig       = r_fail;
    assign Timeout_Sig    = r_timeout;
    assign Err_Count      = r_err_cnt;
    assign First_Err_Addr = r_first_err;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_issue = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start_Sig) begin
                    w_state_nxt = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (w_done) begin
                    w_state_nxt = S_WR_GAP;
                end else if (w_timeout) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_req_issue = !w_en && !bus.Busy_Sig;
                end
            end
            S_WR_GAP: begin
                w_state_nxt = w_last ? S_RD_REQ : S_WR_REQ;
            end
            S_RD_REQ: begin
                if (w_done) begin
                    w_state_nxt = S_RD_GAP;
                end else if (w_timeout) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_req_issue = !w_en && !bus.Busy_Sig;
                end
            end
            S_RD_GAP: begin
                w_state_nxt = w_last ? S_FINISH : S_RD_REQ;
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_addr      <= ADDR_FIRST;
            r_wdog      <= 16'd0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_run       <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= 22'd0;
        end else begin
            if ((r_state == S_IDLE) && Start_Sig) begin
                r_addr      <= ADDR_FIRST;
                r_wdog      <= 16'd0;
                r_run       <= 1'b1;
                r_pass      <= 1'b0;
                r_fail      <= 1'b0;
                r_timeout   <= 1'b0;
                r_err_cnt   <= '0;
                r_first_err <= 22'd0;
            end

            // Watchdog covers the whole REQ stay, including cycles blocked by Busy_Sig.
            if (w_in_req) begin
                r_wdog <= (w_done || w_timeout) ? 16'd0 : r_wdog + 16'd1;
            end

            if (w_done || w_timeout) begin
                r_wr_en <= 1'b0;
                r_rd_en <= 1'b0;
            end else if (w_req_issue) begin
                r_wr_en <= (r_state == S_WR_REQ);
                r_rd_en <= (r_state == S_RD_REQ);
            end

            if (w_timeout) begin
                r_timeout <= 1'b1;
                r_fail    <= 1'b1;
                r_run     <= 1'b0;
            end

            if (w_mismatch) begin
                if (r_err_cnt != c_ERR_MAX) begin
                    r_err_cnt <= r_err_cnt + c_ERR_ONE;
                end
                if (r_err_cnt == '0) begin
                    r_first_err <= r_addr;
                end
            end

            if ((r_state == S_WR_GAP) || (r_state == S_RD_GAP)) begin
                r_addr <= w_last ? ADDR_FIRST : r_addr + 22'd1;
            end

            if ((r_state == S_RD_GAP) && w_last) begin
                r_run <= 1'b0;
            end

            if (r_state == S_FINISH) begin
                r_pass <= (r_err_cnt == '0) && !r_timeout;
                r_fail <= !((r_err_cnt == '0) && !r_timeout);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_rw_tester.sv
`timescale 1ns/1ps
// Bench for sdram_rw_tester: two instances (4-word and 8-word windows) driven
// by a behavioural SDRAM controller with configurable latency and corruption.
module tb_sdram_rw_tester;
    localparam logic [15:0] SEED    = 16'hA5C3;
    localparam int          N_A     = 4;
    localparam int          N_B     = 8;
    localparam logic [21:0] FIRST_A = 22'd0;
    localparam logic [21:0] FIRST_B = 22'd8;

    typedef struct packed {
        bit          wr;
        logic [21:0] addr;
        logic [15:0] data;
    } req_t;

    logic clk = 1'b0;
    logic rst_n, start_a, start_b;
    logic run_a, pass_a, fail_a, tmo_a, run_b, pass_b, fail_b, tmo_b;
    logic [7:0]  err_a;
    logic [1:0]  err_b;
    logic [21:0] ferr_a, ferr_b;

    req_t        log_a[$];
    req_t        log_b[$];
    logic [15:0] mem [16];
    bit   [7:0]  corrupt [2];
    bit          nodone  [2];
    bit          randlat [2];
    int          viol    [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sdram_rw_tester_if if_a ();
    sdram_rw_tester_if if_b ();

    sdram_rw_tester #(.ADDR_FIRST(22'd0), .ADDR_LAST(22'd3), .SEED(SEED),
                      .TIMEOUT(16'd16), .ERR_W(8)) u_dut_a (
        .CLK(clk), .RSTn(rst_n), .Start_Sig(start_a), .bus(if_a),
        .Run_Sig(run_a), .Pass_Sig(pass_a), .Fail_Sig(fail_a), .Timeout_Sig(tmo_a),
        .Err_Count(err_a), .First_Err_Addr(ferr_a));

    sdram_rw_tester #(.ADDR_FIRST(22'd8), .ADDR_LAST(22'd15), .SEED(SEED),
                      .TIMEOUT(16'd64), .ERR_W(2)) u_dut_b (
        .CLK(clk), .RSTn(rst_n), .Start_Sig(start_b), .bus(if_b),
        .Run_Sig(run_b), .Pass_Sig(pass_b), .Fail_Sig(fail_b), .Timeout_Sig(tmo_b),
        .Err_Count(err_b), .First_Err_Addr(ferr_b));

    // Behavioural controller: Done after a latency counted from EN rising, memory echo.
    initial begin : controller_model
        int          cnt [2];
        int          lat [2];
        bit          prev_en [2];
        logic [21:0] la_addr [2];
        logic [15:0] la_data [2];
        bit          wr, rd, en, busy, done;
        logic [21:0] addr;
        logic [15:0] wdat, rdat;
        req_t        e;
        if_a.Done_Sig = 1'b0; if_a.RdData = 16'd0;
        if_b.Done_Sig = 1'b0; if_b.RdData = 16'd0;
        for (int i = 0; i < 16; i++) mem[i] = 16'd0;
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; lat[k] = 3; prev_en[k] = 1'b0; la_addr[k] = '0; la_data[k] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                wr   = (k == 1) ? if_b.WrEN_Sig : if_a.WrEN_Sig;
                rd   = (k == 1) ? if_b.RdEN_Sig : if_a.RdEN_Sig;
                addr = (k == 1) ? if_b.BRC_Addr : if_a.BRC_Addr;
                wdat = (k == 1) ? if_b.WrData   : if_a.WrData;
                busy = (k == 1) ? if_b.Busy_Sig : if_a.Busy_Sig;
                done = (k == 1) ? if_b.Done_Sig : if_a.Done_Sig;
                rdat = (k == 1) ? if_b.RdData   : if_a.RdData;
                en   = wr | rd;
                if (wr && rd) viol[k]++;
                if (!rst_n || done) begin
                    done = 1'b0;
                    cnt[k] = 0;
                end else if (en) begin
                    if (!prev_en[k]) begin
                        if (busy) viol[k]++;
                        lat[k] = randlat[k] ? int'($urandom_range(1, 6)) : 3;
                        la_addr[k] = addr;
                        la_data[k] = wdat;
                        cnt[k] = 0;
                    end else if (addr != la_addr[k] || (wr && wdat != la_data[k])) begin
                        viol[k]++;
                    end
                    cnt[k]++;
                    if (cnt[k] == lat[k] && !nodone[k]) begin
                        done = 1'b1;
                        if (wr) mem[addr[3:0]] = wdat;
                        else    rdat = mem[addr[3:0]] ^ {15'd0, corrupt[k][addr[2:0]]};
                        e.wr = wr; e.addr = addr; e.data = wr ? wdat : rdat;
                        if (k == 1) log_b.push_back(e);
                        else        log_a.push_back(e);
                    end
                end
                prev_en[k] = en && rst_n;
                if (k == 1) begin if_b.Done_Sig = done; if_b.RdData = rdat; end
                else        begin if_a.Done_Sig = done; if_a.RdData = rdat; end
            end
        end
    end

    initial begin : global_timeout
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int k);
        @(negedge clk);
        if (k == 1) start_b = 1'b1;
        else        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_end(input int k, output int run_cyc, output bit ok);
        ok = 1'b0;
        run_cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            if ((k == 1) ? (pass_b | fail_b) : (pass_a | fail_a)) begin
                ok = 1'b1;
                break;
            end
            if ((k == 1) ? run_b : run_a) run_cyc++;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    // Reference: every read of an address whose corrupt bit is set is a mismatch.
    task automatic check_status(input string tag, input int k, input bit [7:0] mask, input bit tmo);
        int          n, nerr, emax;
        logic [21:0] first, a, efirst;
        bit          found, exp_pass;
        n = (k == 1) ? N_B : N_A;
        first = (k == 1) ? FIRST_B : FIRST_A;
        emax = (k == 1) ? 3 : 255;
        nerr = 0; efirst = '0; found = 1'b0;
        if (!tmo) begin
            for (int i = 0; i < n; i++) begin
                a = first + 22'(i);
                if (mask[a[2:0]]) begin
                    nerr++;
                    if (!found) begin efirst = a; found = 1'b1; end
                end
            end
        end
        if (nerr > emax) nerr = emax;
        exp_pass = (nerr == 0) && !tmo;
        check({tag, "_err"},  (k == 1) ? {30'd0, err_b} : {24'd0, err_a}, 32'(nerr));
        check({tag, "_ferr"}, (k == 1) ? {10'd0, ferr_b} : {10'd0, ferr_a}, {10'd0, efirst});
        check({tag, "_pass"}, {31'd0, (k == 1) ? pass_b : pass_a}, {31'd0, exp_pass});
        check({tag, "_fail"}, {31'd0, (k == 1) ? fail_b : fail_a}, {31'd0, !exp_pass});
        check({tag, "_tmo"},  {31'd0, (k == 1) ? tmo_b : tmo_a}, {31'd0, tmo});
        check({tag, "_run"},  {31'd0, (k == 1) ? run_b : run_a}, 32'd0);
    endtask

    task automatic check_log(input string tag, input int k);
        int          n, sz, bad;
        logic [21:0] first, a;
        req_t        e;
        n = (k == 1) ? N_B : N_A;
        first = (k == 1) ? FIRST_B : FIRST_A;
        sz = (k == 1) ? log_b.size() : log_a.size();
        bad = 0;
        check({tag, "_len"}, 32'(sz), 32'(2 * n));
        for (int i = 0; i < sz && i < 2 * n; i++) begin
            e = (k == 1) ? log_b[i] : log_a[i];
            a = first + 22'(i % n);
            if (e.wr != (i < n) || e.addr != a || (e.wr && e.data != (a[15:0] ^ SEED))) bad++;
        end
        check({tag, "_seq"}, 32'(bad), 32'd0);
    endtask

    initial begin : stimulus
        int          rc, en_seen;
        bit          ok;
        bit [7:0]    mask;
        logic [15:0] d2;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        if_a.Busy_Sig = 1'b0; if_b.Busy_Sig = 1'b0;
        for (int k = 0; k < 2; k++) begin
            corrupt[k] = 8'd0; nodone[k] = 1'b0; randlat[k] = 1'b0; viol[k] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_wren",  {31'd0, if_a.WrEN_Sig}, 32'd0);
        check("rst_rden",  {31'd0, if_a.RdEN_Sig}, 32'd0);
        check("rst_addr",  {10'd0, if_a.BRC_Addr}, 32'd0);
        check("rst_wdata", {16'd0, if_a.WrData}, 32'd0);
        check("rst_flags", {28'd0, run_a, pass_a, fail_a, tmo_a}, 32'd0);
        check("rst_err",   {24'd0, err_a}, 32'd0);
        check("rst_ferr",  {10'd0, ferr_a}, 32'd0);
        check("rst_b_bus", {9'd0, if_b.WrEN_Sig, if_b.RdEN_Sig, if_b.BRC_Addr}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_wren", {31'd0, if_a.WrEN_Sig}, 32'd0);

        // Clean pass, fixed latency 3
        log_a.delete();
        pulse_start(0);
        check("t1_run", {31'd0, run_a}, 32'd1);
        wait_end(0, rc, ok);
        check("t1_done", {31'd0, ok}, 32'd1);
        check_status("t1", 0, 8'h00, 1'b0);
        check_log("t1", 0);
        d2 = (log_a.size() > 2) ? log_a[2].data : 16'hxxxx;
        check("t1_wrdata2", {16'd0, d2}, 32'h0000A5C1);

        // Single corrupted read at address 2
        log_a.delete();
        corrupt[0] = 8'h04;
        pulse_start(0);
        wait_end(0, rc, ok);
        check("t2_done", {31'd0, ok}, 32'd1);
        check_status("t2", 0, 8'h04, 1'b0);
        check_log("t2", 0);

        // Random latency and random corruption patterns
        randlat[0] = 1'b1;
        for (int it = 0; it < 4; it++) begin
            mask = 8'($urandom_range(0, 15));
            corrupt[0] = mask;
            log_a.delete();
            pulse_start(0);
            wait_end(0, rc, ok);
            check("rnd_a_done", {31'd0, ok}, 32'd1);
            check_status("rnd_a", 0, mask, 1'b0);
            check_log("rnd_a", 0);
        end
        randlat[0] = 1'b0;
        corrupt[0] = 8'd0;

        // Controller never answers: watchdog expires after 16 REQ cycles
        nodone[0] = 1'b1;
        log_a.delete();
        pulse_start(0);
        wait_end(0, rc, ok);
        check("t4_done", {31'd0, ok}, 32'd1);
        check("t4_req_cycles", 32'(rc), 32'd16);
        check("t4_wren_low", {31'd0, if_a.WrEN_Sig}, 32'd0);
        check("t4_no_done", 32'(log_a.size()), 32'd0);
        check_status("t4", 0, 8'h00, 1'b1);
        nodone[0] = 1'b0;

        // Reset asserted while a write request is open
        pulse_start(0);
        en_seen = 0;
        for (int i = 0; i < 20 && en_seen == 0; i++) begin
            @(negedge clk);
            if (if_a.WrEN_Sig) en_seen = 1;
        end
        check("t6_wren_seen", 32'(en_seen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_wren", {31'd0, if_a.WrEN_Sig}, 32'd0);
        check("t6_async_run",  {31'd0, run_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        log_a.delete();
        pulse_start(0);
        repeat (10) @(negedge clk);
        pulse_start(0);
        wait_end(0, rc, ok);
        check("t6_done", {31'd0, ok}, 32'd1);
        check_status("t6", 0, 8'h00, 1'b0);
        check_log("t6", 0);

        // Busy held at start: no request until it drops
        log_b.delete();
        @(negedge clk);
        if_b.Busy_Sig = 1'b1;
        pulse_start(1);
        check("t3_run", {31'd0, run_b}, 32'd1);
        en_seen = 0;
        repeat (18) begin
            @(negedge clk);
            if (if_b.WrEN_Sig || if_b.RdEN_Sig) en_seen++;
        end
        check("t3_no_en_busy", 32'(en_seen), 32'd0);
        if_b.Busy_Sig = 1'b0;
        wait_end(1, rc, ok);
        check("t3_done", {31'd0, ok}, 32'd1);
        check_status("t3", 1, 8'h00, 1'b0);
        check_log("t3", 1);

        // Every read wrong in 8-word window: 2-bit counter saturates
        log_b.delete();
        corrupt[1] = 8'hFF;
        pulse_start(1);
        wait_end(1, rc, ok);
        check("t5_done", {31'd0, ok}, 32'd1);
        check_status("t5", 1, 8'hFF, 1'b0);
        check_log("t5", 1);

        randlat[1] = 1'b1;
        for (int it = 0; it < 3; it++) begin
            mask = 8'($urandom_range(0, 255));
            corrupt[1] = mask;
            log_b.delete();
            pulse_start(1);
            wait_end(1, rc, ok);
            check("rnd_b_done", {31'd0, ok}, 32'd1);
            check_status("rnd_b", 1, mask, 1'b0);
            check_log("rnd_b", 1);
        end

        check("proto_a", 32'(viol[0]), 32'd0);
        check("proto_b", 32'(viol[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
